// File: rtl/tile_pkg.sv
// Shared constants and helpers for the tile lane shifter.
// Taps are maximal-length Fibonacci XOR positions for widths 8..32.
package tile_pkg;

    localparam int EMPTY_LANE = 0;

    function automatic logic [31:0] lfsr_taps(input int width);
        case (width)
            8:       return 32'h0000_00B8;
            9:       return 32'h0000_0110;
            10:      return 32'h0000_0240;
            11:      return 32'h0000_0500;
            12:      return 32'h0000_0829;
            13:      return 32'h0000_100D;
            14:      return 32'h0000_2015;
            15:      return 32'h0000_6000;
            16:      return 32'h0000_D008;
            17:      return 32'h0001_2000;
            18:      return 32'h0002_0400;
            19:      return 32'h0004_0023;
            20:      return 32'h0009_0000;
            21:      return 32'h0014_0000;
            22:      return 32'h0030_0000;
            23:      return 32'h0042_0000;
            24:      return 32'h00E1_0000;
            25:      return 32'h0120_0000;
            26:      return 32'h0200_0023;
            27:      return 32'h0400_0013;
            28:      return 32'h0900_0000;
            29:      return 32'h1400_0000;
            30:      return 32'h2000_0029;
            31:      return 32'h4800_0000;
            32:      return 32'h8020_0003;
            default: return 32'h0000_00B8;
        endcase
    endfunction

    function automatic int lane_w(input int lanes);
        return $clog2(lanes + 1);
    endfunction

endpackage

// File: rtl/tile_lane_shifter_if.sv
// Control/status bundle between the game FSM, the shifter and the renderer.
// master = game side driving strobes, slave = the shifter itself.
interface tile_lane_shifter_if #(
    parameter int LANE_W = 4,
    parameter int DEPTH  = 7,
    parameter int LFSR_W = 16,
    parameter int CNT_W  = 16
);
    logic                    shift;
    logic                    hit;
    logic [LANE_W-1:0]       hit_lane;
    logic [3:0]              blank_thr;
    logic                    seed_load;
    logic [LFSR_W-1:0]       seed_in;
    logic [DEPTH*LANE_W-1:0] rows_flat;
    logic                    hit_ok;
    logic                    hit_bad;
    logic                    miss;
    logic [CNT_W-1:0]        hit_count;
    logic [CNT_W-1:0]        miss_count;

    modport master (
        output shift, hit, hit_lane, blank_thr, seed_load, seed_in,
        input  rows_flat, hit_ok, hit_bad, miss, hit_count, miss_count
    );

    modport slave (
        input  shift, hit, hit_lane, blank_thr, seed_load, seed_in,
        output rows_flat, hit_ok, hit_bad, miss, hit_count, miss_count
    );
endinterface

// File: rtl/tile_lfsr.sv
// Free-running Fibonacci LFSR with seed load and lock-up guard.
// A zero load value falls back to SEED so the register never parks at 0.
module tile_lfsr
    import tile_pkg::*;
#(
    parameter int                LFSR_W = 16,
    parameter logic [LFSR_W-1:0] SEED   = 16'hACE1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [LFSR_W-1:0] load_val,
    output logic [LFSR_W-1:0] state
);

    localparam logic [31:0] TAPS = lfsr_taps(LFSR_W);

    logic [LFSR_W-1:0] nxt;
    logic              fb;

    always_comb begin
        fb  = ^(state & TAPS[LFSR_W-1:0]);
        nxt = {state[LFSR_W-2:0], fb};
        if (load) begin
            nxt = (load_val == '0) ? SEED : load_val;
        end else if (state == '0) begin
            nxt = LFSR_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= SEED;
        end else begin
            state <= nxt;
        end
    end

endmodule

// File: rtl/tile_lane_shifter.sv
// Scrolling playfield of lane codes with random row insertion,
// bottom-row hit resolution, miss detection and saturating counters.
module tile_lane_shifter
    import tile_pkg::*;
#(
    parameter int                LANES     = 4,
    parameter int                DEPTH     = 7,
    parameter int                LANE_W    = 4,
    parameter int                LFSR_W    = 16,
    parameter logic [LFSR_W-1:0] SEED      = 16'hACE1,
    parameter int                NO_REPEAT = 1,
    parameter int                CNT_W     = 16
) (
    input  logic               clk,
    input  logic               reset,
    tile_lane_shifter_if.slave bus
);

    typedef logic [LANE_W-1:0] lane_t;

    localparam lane_t LANE_E   = lane_t'(EMPTY_LANE);
    localparam lane_t LANE_1   = lane_t'(1);
    localparam lane_t LANE_MAX = lane_t'(LANES);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    lane_t             rows [DEPTH];
    logic [LFSR_W-1:0] r;
    lane_t             raw;
    lane_t             cand;
    lane_t             new_row;
    lane_t             bot;
    logic              match;
    logic              ok_q;
    logic              bad_q;
    logic              miss_q;
    logic [CNT_W-1:0]  hit_cnt;
    logic [CNT_W-1:0]  miss_cnt;
    logic              unused_r;

    tile_lfsr #(
        .LFSR_W (LFSR_W),
        .SEED   (SEED)
    ) u_lfsr (
        .clk      (clk),
        .reset    (reset),
        .load     (bus.seed_load),
        .load_val (bus.seed_in),
        .state    (r)
    );

    assign unused_r = ^r;

    // Scale the low byte onto 1..LANES, then dodge the current top lane.
    always_comb begin
        raw  = lane_t'((16'(r[7:0]) * 16'(LANES)) >> 8) + LANE_1;
        cand = raw;
        if (NO_REPEAT != 0 && raw == rows[0]) begin
            cand = (raw == LANE_MAX) ? LANE_1 : raw + LANE_1;
        end
        new_row = cand;
        if (r[LFSR_W-1 -: 4] < bus.blank_thr) begin
            new_row = LANE_E;
        end
    end

    assign bot   = rows[DEPTH-1];
    assign match = bus.hit && (bot != LANE_E) && (bus.hit_lane == bot);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                rows[i] <= LANE_E;
            end
        end else if (bus.shift) begin
            rows[0] <= new_row;
            for (int i = 1; i < DEPTH; i++) begin
                rows[i] <= rows[i-1];
            end
        end else if (match) begin
            rows[DEPTH-1] <= LANE_E;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ok_q     <= 1'b0;
            bad_q    <= 1'b0;
            miss_q   <= 1'b0;
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else begin
            ok_q   <= match;
            bad_q  <= bus.hit && !match;
            miss_q <= bus.shift && (bot != LANE_E) && !match;
            if (match && hit_cnt != CNT_MAX) begin
                hit_cnt <= hit_cnt + CNT_W'(1);
            end
            if (bus.shift && (bot != LANE_E) && !match
                && miss_cnt != CNT_MAX) begin
                miss_cnt <= miss_cnt + CNT_W'(1);
            end
        end
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_flat
        assign bus.rows_flat[g*LANE_W +: LANE_W] = rows[g];
    end

    assign bus.hit_ok     = ok_q;
    assign bus.hit_bad    = bad_q;
    assign bus.miss       = miss_q;
    assign bus.hit_count  = hit_cnt;
    assign bus.miss_count = miss_cnt;

endmodule

// File: tb/tb_tile_lane_shifter.sv
// Scoreboard bench for tile_lane_shifter: random play against a
// queue-based playfield model, checked by an independent monitor.
module tb_tile_lane_shifter;
    import tile_pkg::*;

    localparam int LANES     = 4;
    localparam int DEPTH     = 7;
    localparam int LANE_W    = 4;
    localparam int LFSR_W    = 16;
    localparam int CNT_W     = 4;
    localparam int NO_REPEAT = 1;
    localparam int SEEDV     = 16'hACE1;
    localparam int CMAX      = (1 << CNT_W) - 1;
    localparam int RW        = DEPTH * LANE_W;

    logic clk = 1'b0;
    logic reset = 1'b1;

    always #5 clk = ~clk;

    tile_lane_shifter_if #(
        .LANE_W (LANE_W),
        .DEPTH  (DEPTH),
        .LFSR_W (LFSR_W),
        .CNT_W  (CNT_W)
    ) bus ();

    tile_lane_shifter #(
        .LANES     (LANES),
        .DEPTH     (DEPTH),
        .LANE_W    (LANE_W),
        .LFSR_W    (LFSR_W),
        .SEED      (16'hACE1),
        .NO_REPEAT (NO_REPEAT),
        .CNT_W     (CNT_W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [RW-1:0] rows;
        bit            ok;
        bit            bad;
        bit            miss;
        int            hc;
        int            mc;
        bit            sh;
    } exp_t;

    exp_t sbq[$];
    int   tests = 0;
    int   fails = 0;

    int m_rows[$];
    int m_lfsr;
    int m_hc;
    int m_mc;

    bit cnt_blank = 0;
    bit chk_rep = 0;
    int blanks = 0;
    int shifts_seen = 0;
    int rep_viol = 0;
    int last_row0 = 0;

    task automatic chk(string name, longint act, longint want);
        tests++;
        if (act != want) begin
            fails++;
            $display("FAIL %s: got %0d want %0d at %0t", name, act, want, $time);
        end
    endtask

    function automatic int lfsr_next(int s);
        int t;
        int fb;
        t  = lfsr_taps(LFSR_W);
        fb = $countones(s & t) & 1;
        return ((s << 1) | fb) & ((1 << LFSR_W) - 1);
    endfunction

    function automatic logic [RW-1:0] pack();
        logic [RW-1:0] v;
        int            x;
        v = '0;
        for (int i = 0; i < DEPTH; i++) begin
            x = m_rows[i];
            v[i*LANE_W +: LANE_W] = x[LANE_W-1:0];
        end
        return v;
    endfunction

    task automatic model_reset();
        m_rows = {};
        for (int i = 0; i < DEPTH; i++) m_rows.push_back(0);
        m_lfsr = SEEDV;
        m_hc   = 0;
        m_mc   = 0;
    endtask

    // Drive one cycle of stimulus at a falling edge and predict the result.
    task automatic step(bit sh, bit h, int hl, int thr,
                        bit sl = 0, int si = 0);
        exp_t e;
        int   r;
        int   cand;
        int   nr;
        int   b;
        bit   good;
        bus.shift     = sh;
        bus.hit       = h;
        bus.hit_lane  = hl[LANE_W-1:0];
        bus.blank_thr = thr[3:0];
        bus.seed_load = sl;
        bus.seed_in   = si[LFSR_W-1:0];
        r    = m_lfsr;
        cand = ((r % 256) * LANES) / 256 + 1;
        if (NO_REPEAT != 0 && cand == m_rows[0])
            cand = (cand == LANES) ? 1 : cand + 1;
        nr   = (((r >> (LFSR_W - 4)) % 16) < thr) ? 0 : cand;
        b    = m_rows[DEPTH-1];
        good = h && b != 0 && hl == b;
        e.ok   = good;
        e.bad  = h && !good;
        e.miss = sh && b != 0 && !good;
        if (good && m_hc < CMAX) m_hc++;
        if (e.miss && m_mc < CMAX) m_mc++;
        if (sh) begin
            void'(m_rows.pop_back());
            m_rows.push_front(nr);
        end else if (good) begin
            m_rows[DEPTH-1] = 0;
        end
        if (sl) m_lfsr = (si == 0) ? SEEDV : si;
        else if (m_lfsr == 0) m_lfsr = 1;
        else m_lfsr = lfsr_next(m_lfsr);
        e.rows = pack();
        e.hc   = m_hc;
        e.mc   = m_mc;
        e.sh   = sh;
        sbq.push_back(e);
        @(negedge clk);
    endtask

    exp_t mon_e;
    int   mon_r0;

    always @(posedge clk) begin
        #1;
        if (sbq.size() > 0) begin
            mon_e  = sbq.pop_front();
            mon_r0 = int'(bus.rows_flat[LANE_W-1:0]);
            chk("rows", bus.rows_flat, mon_e.rows);
            chk("hit_ok", bus.hit_ok, mon_e.ok);
            chk("hit_bad", bus.hit_bad, mon_e.bad);
            chk("miss", bus.miss, mon_e.miss);
            chk("hit_count", bus.hit_count, mon_e.hc);
            chk("miss_count", bus.miss_count, mon_e.mc);
            if (cnt_blank && mon_e.sh) begin
                shifts_seen++;
                if (mon_r0 == 0) blanks++;
            end
            if (chk_rep && mon_e.sh && mon_r0 == last_row0) rep_viol++;
            last_row0 = mon_r0;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [RW-1:0] snap;
        int            v;
        bit            found;
        bus.shift     = 1'b0;
        bus.hit       = 1'b0;
        bus.hit_lane  = '0;
        bus.blank_thr = '0;
        bus.seed_load = 1'b0;
        bus.seed_in   = '0;
        model_reset();
        repeat (3) @(negedge clk);
        chk("rst_rows", bus.rows_flat, 0);
        chk("rst_hc", bus.hit_count, 0);
        chk("rst_mc", bus.miss_count, 0);
        chk("rst_pulses", {bus.hit_ok, bus.hit_bad, bus.miss}, 0);
        reset = 1'b0;

        for (int i = 0; i < DEPTH; i++) step(1, 0, 0, 0);
        snap = pack();
        for (int i = 0; i < DEPTH; i++) begin
            v = int'(bus.rows_flat[i*LANE_W +: LANE_W]);
            chk("row_in_range", (v >= 1 && v <= LANES), 1);
        end

        chk_rep = 1;
        for (int i = 0; i < 200; i++)
            step(1, $urandom_range(0, 3) == 0, $urandom_range(0, LANES + 1), 0);
        chk_rep = 0;
        chk("no_repeat", rep_viol, 0);
        chk("miss_sat", bus.miss_count, CMAX);

        found = 0;
        for (int k = 0; k < 300 && !found; k++) begin
            if (m_rows[DEPTH-1] == 3) begin
                step(0, 1, 3, 0);
                found = 1;
                chk("hit_clear", bus.rows_flat[(DEPTH-1)*LANE_W +: LANE_W], 0);
            end else step(1, 0, 0, 0);
        end
        chk("find_b3", found, 1);

        found = 0;
        for (int k = 0; k < 300 && !found; k++) begin
            if (m_rows[DEPTH-1] != 0 && m_rows[DEPTH-1] != 2) begin
                v = m_rows[DEPTH-1];
                step(0, 1, 2, 0);
                found = 1;
                chk("bad_keep", bus.rows_flat[(DEPTH-1)*LANE_W +: LANE_W], v);
                step(0, 1, 0, 0);
                step(0, 1, LANES + 3, 0);
            end else step(1, 0, 0, 0);
        end
        chk("find_bad", found, 1);

        for (int pass = 0; pass < 2; pass++) begin
            found = 0;
            for (int k = 0; k < 300 && !found; k++) begin
                if (m_rows[DEPTH-1] == 2) begin
                    step(1, pass == 1, 2, 0);
                    found = 1;
                end else step(1, 0, 0, 0);
            end
            chk("find_b2", found, 1);
        end

        step(0, 0, 0, 0, 1, 16'h1234);
        for (int i = 0; i < 5; i++) step(1, 1, $urandom_range(1, LANES), 0);

        cnt_blank = 1;
        for (int i = 0; i < 1024; i++)
            step(1, $urandom_range(0, 7) == 0, $urandom_range(0, LANES), 15);
        cnt_blank = 0;
        chk("blank_shifts", shifts_seen, 1024);
        chk("blank_ratio", (blanks >= 900 && blanks <= 1010), 1);

        for (int i = 0; i < 4; i++) step(1, 0, 0, 0);
        bus.shift = 1'b1;
        #2;
        reset = 1'b1;
        #1;
        chk("async_rows", bus.rows_flat, 0);
        chk("async_hc", bus.hit_count, 0);
        chk("async_mc", bus.miss_count, 0);
        chk("async_pulses", {bus.hit_ok, bus.hit_bad, bus.miss}, 0);
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        step(0, 0, 0, 0, 1, 0);
        for (int i = 0; i < DEPTH; i++) step(1, 0, 0, 0);
        chk("replay", bus.rows_flat, snap);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
